// File: rtl/object_bounce_engine_if.sv
// object_bounce_engine_if
//   Bundle between the game-object logic (master) and the bounce engine
//   (slave). The master supplies the sprite geometry, the initial position and
//   direction, and the per-axis step periods. The slave returns the current
//   position and the registered edge-contact flags.
//
//   width    [9:0]  sprite width in pixels
//   height   [8:0]  sprite height in pixels
//   initposx [9:0]  x position loaded while reset is asserted
//   initposy [8:0]  y position loaded while reset is asserted
//   Tx, Ty   [31:0] clocks per 1-pixel step (0 freezes the axis)
//   dx, dy          initial direction (1 = +x right / +y down)
//   posx     [9:0]  sprite left edge
//   posy     [8:0]  sprite top edge
//   flagx, flagy    registered edge contact per axis
//   oob             registered flagx | flagy
interface object_bounce_engine_if;
  logic [9:0]  width;
  logic [8:0]  height;
  logic [9:0]  initposx;
  logic [8:0]  initposy;
  logic [31:0] Tx;
  logic [31:0] Ty;
  logic        dx;
  logic        dy;
  logic [9:0]  posx;
  logic [8:0]  posy;
  logic        oob;
  logic        flagx;
  logic        flagy;

  modport master (
    output width, height, initposx, initposy, Tx, Ty, dx, dy,
    input  posx, posy, oob, flagx, flagy
  );

  modport slave (
    input  width, height, initposx, initposy, Tx, Ty, dx, dy,
    output posx, posy, oob, flagx, flagy
  );
endinterface

// File: rtl/object_bounce_engine.sv
// object_bounce_engine
//   Steps one rectangular sprite across a SCREEN_W x SCREEN_H screen at a
//   programmable period per axis, clamps it inside the screen, and reverses
//   an axis when the sprite touches that axis' edge while heading outward.
//
//   clk  system clock
//   rst  asynchronous, active-low reset; loads the initial position and
//        direction from the bus and clears counters and flags
//   bus  object_bounce_engine_if.slave (geometry, periods, init values in;
//        position and edge flags out)
module object_bounce_engine #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  object_bounce_engine_if.slave bus
);

  localparam logic [10:0] SCR_W = 11'(SCREEN_W);
  localparam logic [9:0]  SCR_H = 10'(SCREEN_H);

  logic [31:0] cx;
  logic [31:0] cy;
  logic [9:0]  posx;
  logic [8:0]  posy;
  logic        xdir;
  logic        ydir;
  logic        flagx;
  logic        flagy;
  logic        oob;

  // Extended sums keep the edge compares free of truncation.
  logic [10:0] sumx;
  logic [10:0] sumx_nxt;
  logic [9:0]  sumy;
  logic [9:0]  sumy_nxt;
  logic        at_left;
  logic        at_right;
  logic        at_top;
  logic        at_bottom;
  logic        step_x;
  logic        step_y;
  logic        wide_x;
  logic        tall_y;

  always_comb begin
    sumx      = {1'b0, posx} + {1'b0, bus.width};
    sumx_nxt  = sumx + 11'd1;
    sumy      = {1'b0, posy} + {1'b0, bus.height};
    sumy_nxt  = sumy + 10'd1;
    at_left   = (posx == 10'd0);
    at_right  = (sumx >= SCR_W);
    at_top    = (posy == 9'd0);
    at_bottom = (sumy >= SCR_H);
    step_x    = (bus.Tx != 32'd0) && (cx == bus.Tx - 32'd1);
    step_y    = (bus.Ty != 32'd0) && (cy == bus.Ty - 32'd1);
    wide_x    = ({1'b0, bus.width} >= SCR_W);
    tall_y    = ({1'b0, bus.height} >= SCR_H);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cx    <= '0;
      cy    <= '0;
      posx  <= bus.initposx;
      posy  <= bus.initposy;
      xdir  <= bus.dx;
      ydir  <= bus.dy;
      flagx <= 1'b0;
      flagy <= 1'b0;
      oob   <= 1'b0;
    end else begin
      // Period counters; lowering the period below the count lets it wrap.
      if (bus.Tx == 32'd0)  cx <= '0;
      else if (step_x)      cx <= '0;
      else                  cx <= cx + 32'd1;

      if (bus.Ty == 32'd0)  cy <= '0;
      else if (step_y)      cy <= '0;
      else                  cy <= cy + 32'd1;

      // Steps use the current direction; a step past either limit is dropped.
      if (wide_x) begin
        posx <= '0;
      end else if (step_x) begin
        if (xdir && (sumx_nxt <= SCR_W))   posx <= posx + 10'd1;
        else if (!xdir && !at_left)        posx <= posx - 10'd1;
      end

      if (tall_y) begin
        posy <= '0;
      end else if (step_y) begin
        if (ydir && (sumy_nxt <= SCR_H))   posy <= posy + 9'd1;
        else if (!ydir && !at_top)         posy <= posy - 9'd1;
      end

      flagx <= at_left || at_right;
      flagy <= at_top || at_bottom;
      oob   <= at_left || at_right || at_top || at_bottom;

      // Directions are forced inward rather than toggled, so a flag held
      // across many cycles cannot make the sprite oscillate.
      if (flagx && at_left && !xdir)       xdir <= 1'b1;
      else if (flagx && at_right && xdir)  xdir <= 1'b0;

      if (flagy && at_top && !ydir)        ydir <= 1'b1;
      else if (flagy && at_bottom && ydir) ydir <= 1'b0;
    end
  end

  assign bus.posx  = posx;
  assign bus.posy  = posy;
  assign bus.flagx = flagx;
  assign bus.flagy = flagy;
  assign bus.oob   = oob;

endmodule

// File: tb/tb_object_bounce_engine.sv
// tb_object_bounce_engine
//   Directed vectors with hand-computed expectations for object_bounce_engine.
//   Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_object_bounce_engine;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  object_bounce_engine_if bus();

  object_bounce_engine #(.SCREEN_W(640), .SCREEN_H(480)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds reset for two clocks with the given setup, checks the reset state,
  // then releases reset 1 ns after a rising edge.
  task automatic start(input int w, input int h, input int ix, input int iy,
                       input int tx, input int ty, input bit ddx, input bit ddy);
    rst          = 1'b0;
    bus.width    = 10'(w);
    bus.height   = 9'(h);
    bus.initposx = 10'(ix);
    bus.initposy = 9'(iy);
    bus.Tx       = 32'(tx);
    bus.Ty       = 32'(ty);
    bus.dx       = ddx;
    bus.dy       = ddy;
    tick(2);
    chk("rst_posx",  32'(bus.posx),  32'(ix));
    chk("rst_posy",  32'(bus.posy),  32'(iy));
    chk("rst_flagx", 32'(bus.flagx), 32'd0);
    chk("rst_flagy", 32'(bus.flagy), 32'd0);
    chk("rst_oob",   32'(bus.oob),   32'd0);
    rst = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;

    // Basic stepping
    start(16, 16, 100, 50, 4, 8, 1'b1, 1'b1);
    tick(3); chk("t1_posx_c3", 32'(bus.posx), 32'd100);
    tick(1); chk("t1_posx_c4", 32'(bus.posx), 32'd101);
             chk("t1_flagx",   32'(bus.flagx), 32'd0);
    tick(4); chk("t1_posy_c8", 32'(bus.posy), 32'd51);
             chk("t1_posx_c8", 32'(bus.posx), 32'd102);
             chk("t1_oob",     32'(bus.oob),  32'd0);

    // Right-edge bounce
    start(40, 16, 598, 200, 1, 0, 1'b1, 1'b1);
    tick(1); chk("t2_posx_c1", 32'(bus.posx), 32'd599);
    tick(1); chk("t2_posx_c2", 32'(bus.posx), 32'd600);
             chk("t2_flag_c2", 32'(bus.flagx), 32'd0);
    tick(1); chk("t2_posx_c3", 32'(bus.posx), 32'd600);
             chk("t2_flag_c3", 32'(bus.flagx), 32'd1);
    tick(1); chk("t2_posx_c4", 32'(bus.posx), 32'd600);
             chk("t2_oob_c4",  32'(bus.oob),  32'd1);
    tick(1); chk("t2_posx_c5", 32'(bus.posx), 32'd599);
             chk("t2_flag_c5", 32'(bus.flagx), 32'd1);
    tick(1); chk("t2_posx_c6", 32'(bus.posx), 32'd598);
             chk("t2_flag_c6", 32'(bus.flagx), 32'd0);
    tick(1); chk("t2_posx_c7", 32'(bus.posx), 32'd597);

    // Top bounce
    start(16, 20, 100, 1, 0, 2, 1'b1, 1'b0);
    tick(2); chk("t3_posy_c2", 32'(bus.posy), 32'd0);
             chk("t3_flag_c2", 32'(bus.flagy), 32'd0);
    tick(1); chk("t3_flag_c3", 32'(bus.flagy), 32'd1);
             chk("t3_oob_c3",  32'(bus.oob),   32'd1);
    tick(2); chk("t3_posy_c5", 32'(bus.posy), 32'd0);
    tick(1); chk("t3_posy_c6", 32'(bus.posy), 32'd1);
             chk("t3_oob_c6",  32'(bus.oob),  32'd1);
    tick(1); chk("t3_flag_c7", 32'(bus.flagy), 32'd0);
             chk("t3_oob_c7",  32'(bus.oob),   32'd0);
    tick(1); chk("t3_posy_c8", 32'(bus.posy), 32'd2);
             chk("t3_posx",    32'(bus.posx), 32'd100);

    // Corner
    start(16, 16, 0, 0, 1, 1, 1'b0, 1'b0);
    tick(1); chk("t4_flagx_c1", 32'(bus.flagx), 32'd1);
             chk("t4_flagy_c1", 32'(bus.flagy), 32'd1);
             chk("t4_oob_c1",   32'(bus.oob),   32'd1);
    tick(1); chk("t4_posx_c2",  32'(bus.posx),  32'd0);
             chk("t4_posy_c2",  32'(bus.posy),  32'd0);
    tick(1); chk("t4_posx_c3",  32'(bus.posx),  32'd1);
             chk("t4_posy_c3",  32'(bus.posy),  32'd1);
    tick(1); chk("t4_posx_c4",  32'(bus.posx),  32'd2);
             chk("t4_posy_c4",  32'(bus.posy),  32'd2);
             chk("t4_oob_c4",   32'(bus.oob),   32'd0);

    // Freeze, then resume x with a live period change
    start(16, 16, 300, 200, 0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(250);
      chk("t5_frz_posx", 32'(bus.posx), 32'd300);
      chk("t5_frz_posy", 32'(bus.posy), 32'd200);
    end
    bus.Tx = 32'd3;
    tick(2); chk("t5_posx_c2", 32'(bus.posx), 32'd300);
    tick(1); chk("t5_posx_c3", 32'(bus.posx), 32'd301);
    tick(3); chk("t5_posx_c6", 32'(bus.posx), 32'd302);
             chk("t5_posy",    32'(bus.posy), 32'd200);

    // Async reset mid-run, while flagx is high
    start(40, 16, 598, 200, 1, 0, 1'b1, 1'b1);
    tick(4); chk("t6_pre_posx", 32'(bus.posx),  32'd600);
             chk("t6_pre_flag", 32'(bus.flagx), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_posx",  32'(bus.posx),  32'd598);
    chk("t6_posy",  32'(bus.posy),  32'd200);
    chk("t6_flagx", 32'(bus.flagx), 32'd0);
    chk("t6_oob",   32'(bus.oob),   32'd0);

    // Sprite as wide as the screen is pinned to x=0
    start(640, 16, 5, 100, 1, 0, 1'b1, 1'b1);
    tick(1); chk("t7_posx_c1",  32'(bus.posx),  32'd0);
             chk("t7_flagx_c1", 32'(bus.flagx), 32'd1);
    tick(3); chk("t7_posx_c4",  32'(bus.posx),  32'd0);

    // Bottom clamp
    start(16, 20, 100, 458, 0, 1, 1'b1, 1'b1);
    tick(2); chk("t8_posy_c2",  32'(bus.posy),  32'd460);
             chk("t8_flagy_c2", 32'(bus.flagy), 32'd0);
    tick(1); chk("t8_posy_c3",  32'(bus.posy),  32'd460);
             chk("t8_flagy_c3", 32'(bus.flagy), 32'd1);
    tick(2); chk("t8_posy_c5",  32'(bus.posy),  32'd459);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/object_bounce_engine.md
Name: object_bounce_engine

Overview:
- Moves one rectangular sprite over a 640x480 screen at programmable per-axis step periods.
- Detects contact with the screen edges and reverses the offending axis direction, so the sprite bounces.
- Combines a position stepper (transition) and a bound checker (out-of-bound) into one block.
- Sits between the game-object logic (init position, speed, size) and the renderer (posx/posy).

Parameters:
- SCREEN_W, 640, screen width in pixels.
- SCREEN_H, 480, screen height in pixels.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- width  input  10  sprite width in pixels.
- height  input  9  sprite height in pixels.
- initposx  input  10  x position loaded at reset.
- initposy  input  9  y position loaded at reset.
- Tx  input  32  clock cycles per 1-pixel x step; 0 freezes x.
- Ty  input  32  clock cycles per 1-pixel y step; 0 freezes y.
- dx  input  1  initial x direction loaded at reset (1 = +x/right, 0 = -x/left).
- dy  input  1  initial y direction loaded at reset (1 = +y/down, 0 = -y/up).
- posx  output  10  current sprite left edge.
- posy  output  9  current sprite top edge.
- oob  output  1  registered flagx|flagy.
- flagx  output  1  registered x-edge contact.
- flagy  output  1  registered y-edge contact.

Behaviour:
- Reset (rst=0, asynchronous):
  - posx=initposx, posy=initposy.
  - x direction register = dx, y direction register = dy.
  - Both period counters = 0.
  - oob, flagx and flagy = 0.
  - dx/dy/init inputs are sampled only during reset and ignored afterwards.
- X stepping (y is identical, using Ty/height/SCREEN_H):
  - 32-bit counter cx increments each clock.
  - When cx == Tx-1: cx returns to 0 and posx moves by 1 in the current direction.
  - Tx=1 steps every clock. Tx=0 holds cx at 0 and posx frozen.
  - Tx is sampled live; if Tx is lowered below cx, cx wraps through 2^32 (no special handling).
- Clamping:
  - posx never goes below 0 and never exceeds SCREEN_W-width; a step beyond either limit leaves posx unchanged.
  - If width >= SCREEN_W, posx is held at 0.
  - Comparisons use an 11-bit sum (posx+width) for x and a 10-bit sum (posy+height) for y, with no truncation.
- Edge flags (registered, 1-cycle latency from posx/posy):
  - flagx = (posx == 0) OR (posx + width >= SCREEN_W).
  - flagy = (posy == 0) OR (posy + height >= SCREEN_H).
  - oob = flagx | flagy, registered in the same cycle as the flags.
- Direction update, on the clock edge after the flag register is set:
  - flagx && posx == 0 && xdir == 0: xdir becomes 1.
  - flagx && posx+width >= SCREEN_W && xdir == 1: xdir becomes 0.
  - Same rule for y.
  - Directions are set, not toggled. A flag that stays high for many cycles does not cause oscillation, and a sprite that starts on an edge heading inward keeps its direction.
- Corners: both axes are evaluated independently and may reverse in the same cycle.
- A step and a direction change in the same cycle: the step uses the old direction, and clamping prevents overshoot.
- Reset mid-motion restores all initial values immediately.

Test Plan:
1. Basic stepping. Reset with initposx=100, initposy=50, Tx=4, Ty=8, dx=1, dy=1; release rst. Expect posx=101 after 4 clocks and posy=51 after 8 clocks. Flags stay 0.
2. Right-edge bounce. width=40, initposx=598, Tx=1, dx=1. Expect:
   - posx reaches 600 and never goes above 600.
   - flagx=1 one cycle after posx=600.
   - xdir=0 the next cycle; posx then decreases to 599, 598, ...
   - flagx returns to 0.
3. Left/top bounce. initposy=1, dy=0, Ty=2. Expect:
   - posy goes 1 → 0 and holds at 0.
   - flagy=1 one cycle later; ydir becomes 1.
   - posy then climbs.
   - oob pulses high while flagy is high.
4. Corner. initposx=0, initposy=0, dx=0, dy=0, Tx=Ty=1. Expect:
   - flagx=flagy=oob=1 on the first cycle after reset.
   - Both directions flip to 1 in the same cycle.
   - Position then moves diagonally away (1,1), (2,2).
5. Freeze. Tx=0, Ty=0. Expect posx/posy to stay at their init values for 1000 clocks with the counters at 0. Then set Tx=3 mid-run and expect x to resume stepping every 3 clocks.
6. Async reset mid-run. Assert rst=0 between clock edges while moving. Expect posx/posy to return to their init values and the flags to clear immediately, without waiting for a clock edge.
